// File: rtl/laggy_prefix_pipe.sv
// laggy_prefix_pipe: queued prefix popcount of a bitmask up to a matched
// position, delivered with a fixed pop-to-result lag behind valid/ready
// handshakes. Each queued entry carries its own mask snapshot and mode.
module laggy_prefix_pipe #(
  parameter int BITMASK_WIDTH = 128,
  parameter int NUM_ADDERS    = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int LAG_CYCLES    = 8,
  localparam int POS_W = $clog2(BITMASK_WIDTH),
  localparam int OFF_W = POS_W + 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [POS_W-1:0]         in_position,
  input  logic [WEIGHT_WIDTH-1:0]  in_weight,
  input  logic [BITMASK_WIDTH-1:0] in_bitmask,
  input  logic                     in_exclusive,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OFF_W-1:0]         out_offset,
  output logic [POS_W-1:0]         out_position,
  output logic [WEIGHT_WIDTH-1:0]  out_weight,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     busy
);

  localparam int L       = $clog2(NUM_ADDERS);
  localparam int D       = (LAG_CYCLES > L + 2) ? LAG_CYCLES : L + 2;
  localparam int CHUNK   = BITMASK_WIDTH / NUM_ADDERS;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LC_W    = $clog2(D + 1);
  localparam int ENTRY_W = POS_W + WEIGHT_WIDTH + BITMASK_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_REDUCE,
    S_LAG,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Input queue: pointers carry a wrap bit so full/empty fall out of the
  // pointer difference.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] head_entry;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = !fifo_full && !flush && !rst;
  assign push       = in_valid && in_ready;

  // Queue storage write port; left without reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {in_position, in_weight, in_bitmask, in_exclusive};
    end
  end

  // The head is registered into the working registers on pop, so an entry
  // always spends at least one cycle in the queue.
  assign head_entry = mem[rd_ptr_q[AW-1:0]];

  // Pointer next-state; flush rewinds both pointers and drops any push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + CNT_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Working entry and counting datapath
  // ---------------------------------------------------------------------
  state_t                                state_q, state_d;
  logic [LC_W-1:0]                       cnt_q, cnt_d;
  logic [POS_W-1:0]                      work_pos_q, work_pos_d;
  logic [WEIGHT_WIDTH-1:0]               work_weight_q, work_weight_d;
  logic [BITMASK_WIDTH-1:0]              work_bitmask_q, work_bitmask_d;
  logic                                  work_excl_q, work_excl_d;
  logic [NUM_ADDERS-1:0][OFF_W-1:0]      partial_q, partial_d;
  logic [NUM_ADDERS-1:0][OFF_W-1:0]      chunk_cnt;
  logic [BITMASK_WIDTH-1:0]              masked;
  logic                                  out_valid_q, out_valid_d;
  logic [OFF_W-1:0]                      out_offset_q, out_offset_d;
  logic [POS_W-1:0]                      out_position_q, out_position_d;
  logic [WEIGHT_WIDTH-1:0]               out_weight_q, out_weight_d;

  // Keep bit j when it lies at or below the position (inclusive) or strictly
  // below it (exclusive). Comparing at OFF_W bits keeps position 0 exclusive
  // empty and position BITMASK_WIDTH-1 inclusive full.
  genvar gi;
  generate
    for (gi = 0; gi < BITMASK_WIDTH; gi++) begin : g_mask
      localparam logic [OFF_W-1:0] IDX = OFF_W'(gi);
      assign masked[gi] = work_bitmask_q[gi] &
                          (work_excl_q ? (IDX <  {1'b0, work_pos_q})
                                       : (IDX <= {1'b0, work_pos_q}));
    end

    for (gi = 0; gi < NUM_ADDERS; gi++) begin : g_chunk
      logic [OFF_W-1:0] sum;
      // Popcount of one chunk of the masked bitmask.
      always_comb begin
        sum = '0;
        for (int b = 0; b < CHUNK; b++) begin
          sum = sum + OFF_W'(masked[gi*CHUNK + b]);
        end
      end
      assign chunk_cnt[gi] = sum;
    end
  endgenerate

  // Partial sums: captured from the chunk counters in COUNT, then halved
  // pairwise once per REDUCE cycle until partial[0] holds the total.
  always_comb begin
    partial_d = partial_q;
    if (state_q == S_COUNT) begin
      partial_d = chunk_cnt;
    end else if (state_q == S_REDUCE) begin
      for (int i = 0; i < NUM_ADDERS / 2; i++) begin
        partial_d[i] = partial_q[2*i] + partial_q[2*i+1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM. The cycle counter is 0 on the pop edge; the result
  // registers load on the edge where it reaches D. The sum is complete at
  // count L+1, so LAG always covers at least the output-load cycle.
  // ---------------------------------------------------------------------
  // Next-state, pop and result-register logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pop            = 1'b0;
    work_pos_d     = work_pos_q;
    work_weight_d  = work_weight_q;
    work_bitmask_d = work_bitmask_q;
    work_excl_d    = work_excl_q;
    out_valid_d    = out_valid_q;
    out_offset_d   = out_offset_q;
    out_position_d = out_position_q;
    out_weight_d   = out_weight_q;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        cnt_d   = cnt_q + LC_W'(1);
        state_d = (L == 0) ? S_LAG : S_REDUCE;
      end
      S_REDUCE: begin
        cnt_d = cnt_q + LC_W'(1);
        if (cnt_q == LC_W'(L)) state_d = S_LAG;
      end
      S_LAG: begin
        cnt_d = cnt_q + LC_W'(1);
        if (cnt_q == LC_W'(D - 1)) begin
          state_d        = S_HOLD;
          out_valid_d    = 1'b1;
          out_offset_d   = partial_q[0];
          out_position_d = work_pos_q;
          out_weight_d   = work_weight_q;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_COUNT;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      {work_pos_d, work_weight_d, work_bitmask_d, work_excl_d} = head_entry;
    end

    // Abort: result fields keep their last value, only valid drops.
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      pop         = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      work_pos_q     <= '0;
      work_weight_q  <= '0;
      work_bitmask_q <= '0;
      work_excl_q    <= 1'b0;
      partial_q      <= '0;
      out_valid_q    <= 1'b0;
      out_offset_q   <= '0;
      out_position_q <= '0;
      out_weight_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      work_pos_q     <= work_pos_d;
      work_weight_q  <= work_weight_d;
      work_bitmask_q <= work_bitmask_d;
      work_excl_q    <= work_excl_d;
      partial_q      <= partial_d;
      out_valid_q    <= out_valid_d;
      out_offset_q   <= out_offset_d;
      out_position_q <= out_position_d;
      out_weight_q   <= out_weight_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_offset   = out_offset_q;
  assign out_position = out_position_q;
  assign out_weight   = out_weight_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_laggy_prefix_pipe.sv
// tb_laggy_prefix_pipe: scoreboard bench for laggy_prefix_pipe. Instance A
// uses the default parameters, instance B the small sweep configuration.
module tb_laggy_prefix_pipe;

  localparam int BW   = 128;
  localparam int PW   = 7;
  localparam int OW   = 8;
  localparam int CW   = 4;
  localparam int D    = 8;
  localparam int BW_B = 32;
  localparam int PW_B = 5;
  localparam int OW_B = 6;
  localparam int CW_B = 3;
  localparam int D_B  = 4;

  typedef struct {
    int off;
    int pos;
    int wt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic          rst, flush, in_valid, in_ready, in_exclusive;
  logic [PW-1:0] in_position;
  logic [7:0]    in_weight;
  logic [BW-1:0] in_bitmask;
  logic          out_valid, out_ready, busy;
  logic [OW-1:0] out_offset;
  logic [PW-1:0] out_position;
  logic [7:0]    out_weight;
  logic [CW-1:0] fifo_count;

  laggy_prefix_pipe dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_position(in_position),
    .in_weight(in_weight), .in_bitmask(in_bitmask), .in_exclusive(in_exclusive),
    .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
    .out_position(out_position), .out_weight(out_weight),
    .fifo_count(fifo_count), .busy(busy)
  );

  // ---------------- instance B ----------------
  logic            b_rst, b_flush, b_in_valid, b_in_ready, b_in_exclusive;
  logic [PW_B-1:0] b_in_position;
  logic [7:0]      b_in_weight;
  logic [BW_B-1:0] b_in_bitmask;
  logic            b_out_valid, b_out_ready, b_busy;
  logic [OW_B-1:0] b_out_offset;
  logic [PW_B-1:0] b_out_position;
  logic [7:0]      b_out_weight;
  logic [CW_B-1:0] b_fifo_count;

  laggy_prefix_pipe #(
    .BITMASK_WIDTH(32), .NUM_ADDERS(4), .WEIGHT_WIDTH(8),
    .FIFO_DEPTH(4), .LAG_CYCLES(2)
  ) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_position(b_in_position),
    .in_weight(b_in_weight), .in_bitmask(b_in_bitmask), .in_exclusive(b_in_exclusive),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_offset(b_out_offset),
    .out_position(b_out_position), .out_weight(b_out_weight),
    .fifo_count(b_fifo_count), .busy(b_busy)
  );

  // ---------------- reference model & scoreboard ----------------
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   a_rise_q[$];
  int   a_hs_q[$];
  int   b_rise_q[$];
  int   a_push_cyc, b_push_cyc;
  bit   rand_rdy = 1'b0;

  // Prefix count straight from the definition: set bits at indices up to
  // the position (inclusive) or strictly below it (exclusive).
  function automatic int ref_offset(input logic [127:0] bm, input int pos,
                                    input bit excl, input int width);
    int n = 0;
    for (int j = 0; j < width; j++) begin
      if (bm[j] && (excl ? (j < pos) : (j <= pos))) n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor A: compares each accepted result, checks hold stability and
  // timestamps rises/handshakes.
  initial begin
    bit            prev_valid;
    bit            prev_hold;
    logic [OW-1:0] h_off;
    logic [PW-1:0] h_pos;
    logic [7:0]    h_wt;
    int            txn;
    exp_t          e;
    prev_valid = 0; prev_hold = 0; txn = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        prev_hold  = 0;
      end else begin
        if (out_valid && !prev_valid) a_rise_q.push_back(cyc);
        if (prev_hold && out_valid) begin
          check("a_hold_offset", out_offset, h_off);
          check("a_hold_position", out_position, h_pos);
          check("a_hold_weight", out_weight, h_wt);
        end
        if (out_valid && out_ready) begin
          a_hs_q.push_back(cyc + 1);
          if (exp_a.size() == 0) begin
            fail_now("a_spurious", $sformatf("result off=%0d pos=%0d with empty scoreboard", out_offset, out_position));
          end else begin
            e = exp_a.pop_front();
            check("a_offset", out_offset, e.off);
            check("a_position", out_position, e.pos);
            check("a_weight", out_weight, e.wt);
            $display("A txn %0d: pos=%0d wt=%02h offset=%0d expected=%0d", txn, out_position, out_weight, out_offset, e.off);
            txn++;
          end
        end
        prev_hold  = out_valid && !out_ready;
        h_off      = out_offset;
        h_pos      = out_position;
        h_wt       = out_weight;
        prev_valid = out_valid;
      end
    end
  end

  // Monitor B: same scoreboard comparison for the small instance.
  initial begin
    bit   prev_valid;
    int   txn;
    exp_t e;
    prev_valid = 0; txn = 0;
    forever begin
      @(negedge clk);
      if (b_rst) begin
        prev_valid = 0;
      end else begin
        if (b_out_valid && !prev_valid) b_rise_q.push_back(cyc);
        if (b_out_valid && b_out_ready) begin
          if (exp_b.size() == 0) begin
            fail_now("b_spurious", $sformatf("result off=%0d pos=%0d with empty scoreboard", b_out_offset, b_out_position));
          end else begin
            e = exp_b.pop_front();
            check("b_offset", b_out_offset, e.off);
            check("b_position", b_out_position, e.pos);
            check("b_weight", b_out_weight, e.wt);
            $display("B txn %0d: pos=%0d wt=%02h offset=%0d expected=%0d", txn, b_out_position, b_out_weight, b_out_offset, e.off);
            txn++;
          end
        end
        prev_valid = b_out_valid;
      end
    end
  end

  // Random consumer stalls, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_a(input int pos, input int wt, input logic [127:0] bm, input bit ex);
    int guard = 0;
    @(negedge clk);
    in_valid     = 1'b1;
    in_position  = pos[PW-1:0];
    in_weight    = wt[7:0];
    in_bitmask   = bm;
    in_exclusive = ex;
    #1;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      fail_now("a_send_timeout", "in_ready stayed low");
      in_valid = 1'b0;
      return;
    end
    exp_a.push_back('{ref_offset(bm, pos, ex, BW), pos, wt});
    @(posedge clk);
    #1;
    a_push_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic send_b(input int pos, input int wt, input logic [31:0] bm, input bit ex);
    int guard = 0;
    @(negedge clk);
    b_in_valid     = 1'b1;
    b_in_position  = pos[PW_B-1:0];
    b_in_weight    = wt[7:0];
    b_in_bitmask   = bm;
    b_in_exclusive = ex;
    #1;
    while (!b_in_ready && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!b_in_ready) begin
      fail_now("b_send_timeout", "in_ready stayed low");
      b_in_valid = 1'b0;
      return;
    end
    exp_b.push_back('{ref_offset({96'b0, bm}, pos, ex, BW_B), pos, wt});
    @(posedge clk);
    #1;
    b_push_cyc = cyc;
    b_in_valid = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_a.size() != 0) fail_now("a_drain_timeout", $sformatf("%0d results outstanding", exp_a.size()));
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while ((exp_b.size() != 0 || b_out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_b.size() != 0) fail_now("b_drain_timeout", $sformatf("%0d results outstanding", exp_b.size()));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] ones;
    logic [127:0] bm;
    int           n;
    ones = '1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_position = '0;
    in_weight = '0; in_bitmask = '0; in_exclusive = 1'b0; out_ready = 1'b1;
    b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_position = '0;
    b_in_weight = '0; b_in_bitmask = '0; b_in_exclusive = 1'b0; b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("a_rst_in_ready", in_ready, 0);
    check("a_rst_out_valid", out_valid, 0);
    check("a_rst_out_offset", out_offset, 0);
    check("a_rst_out_position", out_position, 0);
    check("a_rst_out_weight", out_weight, 0);
    check("a_rst_busy", busy, 0);
    check("a_rst_fifo_count", fifo_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("a_in_ready_after_rst", in_ready, 1);

    // First result: latency D+1 from the push edge, single-cycle pulse
    a_rise_q.delete();
    send_a(10, 'h5A, ones, 1'b0);
    n = 0;
    while (a_rise_q.size() == 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (a_rise_q.size() == 0) begin
      fail_now("a_first_latency", "out_valid never rose");
    end else begin
      check("a_first_latency", a_rise_q[0] - a_push_cyc, D + 1);
      @(negedge clk);
      #2;
      check("a_pulse_width", out_valid, 0);
    end
    drain_a(100);

    // Boundary offsets
    send_a(10, 'h11, ones, 1'b1);
    send_a(0, 'h22, ones, 1'b1);
    send_a(127, 'h33, ones, 1'b0);
    send_a(0, 'h44, ones, 1'b0);
    send_a(5, 'h55, 128'h0, 1'b0);
    drain_a(200);

    // Backpressure: one entry in flight plus a full queue
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bm = {$urandom, $urandom, $urandom, $urandom};
      send_a($urandom_range(0, 127), k + 1, bm, k[0]);
      if (k == 7) check("a_fifo_count_after_8", fifo_count, 7);
    end
    check("a_fifo_count_full", fifo_count, 8);
    check("a_in_ready_full", in_ready, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("a_held_valid", out_valid, 1);
    repeat (6) @(posedge clk);
    #1;
    check("a_in_ready_still_full", in_ready, 0);
    a_rise_q.delete();
    a_hs_q.delete();
    out_ready = 1'b1;
    drain_a(300);
    check("a_release_handshakes", a_hs_q.size(), 9);
    check("a_release_rises", a_rise_q.size(), 8);
    if (a_rise_q.size() == 8 && a_hs_q.size() == 9) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("a_pop_to_valid_%0d", k), a_rise_q[k] - a_hs_q[k], D);
      end
    end

    // Flush while reducing with three entries queued
    for (int k = 0; k < 4; k++) send_a(20 + k, 'hA0 + k, ones, 1'b0);
    check("a_pre_flush_count", fifo_count, 3);
    check("a_pre_flush_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_a.delete();
    check("a_flush_valid", out_valid, 0);
    check("a_flush_busy", busy, 0);
    check("a_flush_count", fifo_count, 0);
    repeat (12) @(posedge clk);
    send_a(64, 'h77, ones, 1'b1);
    drain_a(100);

    // Random traffic with consumer stalls
    rand_rdy = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      int sel;
      int pos;
      sel = $urandom_range(0, 7);
      if (sel == 0)      bm = ones;
      else if (sel == 1) bm = '0;
      else if (sel == 2) bm = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
      else               bm = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 9);
      pos = (sel == 0) ? 0 : (sel == 1) ? 127 : $urandom_range(0, 127);
      send_a(pos, $urandom_range(0, 255), bm, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) @(posedge clk);
    end
    drain_a(20000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // ---------------- instance B: small configuration ----------------
    #1;
    check("b_rst_in_ready", b_in_ready, 0);
    check("b_rst_out_valid", b_out_valid, 0);
    check("b_rst_busy", b_busy, 0);
    @(negedge clk);
    b_rst = 1'b0;
    #1;
    check("b_in_ready_after_rst", b_in_ready, 1);

    b_rise_q.delete();
    send_b(10, 'h5A, 32'hFFFF_FFFF, 1'b0);
    n = 0;
    while (b_rise_q.size() == 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (b_rise_q.size() == 0) fail_now("b_latency", "out_valid never rose");
    else check("b_latency", b_rise_q[0] - b_push_cyc, D_B + 1);
    drain_b(100);
    send_b(31, 'h01, 32'hFFFF_FFFF, 1'b0);
    send_b(0, 'h02, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 20; k++) begin
      send_b($urandom_range(0, 31), $urandom_range(0, 255), $urandom, $urandom_range(0, 1) == 1);
    end
    drain_b(400);

    // Reset pulse while the entry sits in LAG
    send_b(7, 'hEE, 32'hFFFF_FFFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("b_pre_rst_busy", b_busy, 1);
    b_rst = 1'b1;
    #1;
    exp_b.delete();
    check("b_midrst_valid", b_out_valid, 0);
    check("b_midrst_busy", b_busy, 0);
    check("b_midrst_count", b_fifo_count, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    b_rise_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("b_no_output_after_rst", b_rise_q.size(), 0);
    send_b(15, 'h3C, 32'h0F0F_F0F0, 1'b1);
    n = 0;
    while (b_rise_q.size() == 0 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (b_rise_q.size() == 0) fail_now("b_restart_latency", "out_valid never rose");
    else check("b_restart_latency", b_rise_q[0] - b_push_cyc, D_B + 1);
    drain_b(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
